// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared encodings for the pipelined barrel shifter.
// Op codes, direction constants and a width helper.
package pipelined_barrel_shifter_pkg;

    localparam logic [1:0] OP_ROT = 2'b00;
    localparam logic [1:0] OP_LSL = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// One shift-by-SHIFT step with its valid/ready register slice.
// Shifts when the matching amount bit is set, otherwise passes through.
module shifter_pipe_stage
    import pipelined_barrel_shifter_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int TAG_W  = 4,
    parameter int AMT_W  = 3,
    parameter int SHIFT  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic              in_lr,
    input  logic [1:0]        in_op,
    input  logic              in_sign,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [AMT_W-1:0]  out_amt,
    output logic              out_lr,
    output logic [1:0]        out_op,
    output logic              out_sign,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int BIT = $clog2(SHIFT);
    localparam logic [DATA_W-1:0] ONES = '1;
    localparam logic [DATA_W-1:0] HI_FILL = ~(ONES >> SHIFT);

    logic [DATA_W-1:0] left, right, rotl, rotr, shifted;

    always_comb begin
        left    = in_data << SHIFT;
        right   = in_data >> SHIFT;
        rotl    = left  | (in_data >> (DATA_W - SHIFT));
        rotr    = right | (in_data << (DATA_W - SHIFT));
        shifted = in_data;
        if (in_amt[BIT]) begin
            case (in_op)
                OP_LSL:  shifted = (in_lr == DIR_LEFT) ? left : right;
                // sign is the original MSB, carried from the first stage
                OP_ASR:  shifted = (in_lr == DIR_LEFT) ? left
                                 : (right | (in_sign ? HI_FILL : '0));
                default: shifted = (in_lr == DIR_LEFT) ? rotl : rotr;
            endcase
        end
    end

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_amt   <= '0;
            out_lr    <= 1'b0;
            out_op    <= OP_ROT;
            out_sign  <= 1'b0;
            out_tag   <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= shifted;
            out_amt   <= in_amt;
            out_lr    <= in_lr;
            out_op    <= in_op;
            out_sign  <= in_sign;
            out_tag   <= in_tag;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined rotate/logical/arithmetic barrel shifter.
// One register stage per amount bit, valid/ready on both sides.
module pipelined_barrel_shifter
    import pipelined_barrel_shifter_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int AMT_W  = 3,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic              in_lr,
    input  logic [1:0]        in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag
);

    if (AMT_W != $clog2(DATA_W) || DATA_W < 4 || !is_pow2(DATA_W)) begin : g_bad_cfg
        $error("pipelined_barrel_shifter: bad DATA_W/AMT_W");
    end

    logic              v    [AMT_W+1];
    logic              rdy  [AMT_W+1];
    logic [DATA_W-1:0] d    [AMT_W+1];
    logic [AMT_W-1:0]  amt  [AMT_W+1];
    logic              lr   [AMT_W+1];
    logic [1:0]        op   [AMT_W+1];
    logic              sign [AMT_W+1];
    logic [TAG_W-1:0]  tag  [AMT_W+1];

    assign v[0]    = in_valid;
    assign d[0]    = in_data;
    assign amt[0]  = in_amt;
    assign lr[0]   = in_lr;
    assign op[0]   = in_op;
    assign sign[0] = in_data[DATA_W-1];
    assign tag[0]  = in_tag;
    assign in_ready = rdy[0];

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        shifter_pipe_stage #(
            .DATA_W (DATA_W),
            .TAG_W  (TAG_W),
            .AMT_W  (AMT_W),
            .SHIFT  (1 << k)
        ) u_stage (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_valid  (v[k]),
            .in_ready  (rdy[k]),
            .in_data   (d[k]),
            .in_amt    (amt[k]),
            .in_lr     (lr[k]),
            .in_op     (op[k]),
            .in_sign   (sign[k]),
            .in_tag    (tag[k]),
            .out_valid (v[k+1]),
            .out_ready (rdy[k+1]),
            .out_data  (d[k+1]),
            .out_amt   (amt[k+1]),
            .out_lr    (lr[k+1]),
            .out_op    (op[k+1]),
            .out_sign  (sign[k+1]),
            .out_tag   (tag[k+1])
        );
    end

    assign rdy[AMT_W] = out_ready;
    assign out_valid  = v[AMT_W];
    assign out_data   = d[AMT_W];
    assign out_tag    = tag[AMT_W];

    // control fields are dead once the last shift is applied
    logic unused_tail;
    assign unused_tail = ^{amt[AMT_W], lr[AMT_W], op[AMT_W], sign[AMT_W]};

endmodule
